// File: rtl/symbol_pack.sv
// Packs 7-bit symbols, four per 32-bit word, with packet framing and a sticky error flag.
// Bits [29:28] of each word hold the valid symbol count minus one.
module symbol_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic [6:0]  data_in,
  output logic        ready_out,
  input  logic        ready_in,
  output logic        valid_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic [31:0] data_out,
  output logic        err
);

  localparam int unsigned SYM_W  = 7;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PART_W = SYM_W * (LANES - 1);
  localparam int unsigned LANE_W = SYM_W * LANES;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    lane_cnt;
  logic [PART_W-1:0]   part;
  logic                first_pend;

  logic                accept_c;
  logic                consume_c;
  logic                drop_c;
  logic                restart_c;
  logic                is_first_c;
  logic                complete_c;
  logic [CNT_W-1:0]    idx_c;
  logic [LANE_W-1:0]   lanes_c;
  logic [31:0]         word_c;

  // Output register is free, or is being drained this cycle.
  assign ready_out = !valid_out || ready_in;

  // Lane placement of the incoming symbol; a sop symbol always restarts at lane 0.
  always_comb begin
    accept_c   = valid_in && ready_out;
    consume_c  = valid_out && ready_in;
    drop_c     = accept_c && (state == IDLE) && !sop_in;
    restart_c  = accept_c && (state == IN_PKT) && sop_in;
    idx_c      = sop_in ? '0 : lane_cnt;
    is_first_c = sop_in || first_pend;
    complete_c = eop_in || (idx_c == CNT_W'(LANES - 1));
    lanes_c    = sop_in ? '0 : {SYM_W'(0), part};
    case (idx_c)
      2'd0:    lanes_c[6:0]   = data_in;
      2'd1:    lanes_c[13:7]  = data_in;
      2'd2:    lanes_c[20:14] = data_in;
      default: lanes_c[27:21] = data_in;
    endcase
    word_c = {2'b00, idx_c, lanes_c};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lane_cnt   <= '0;
      part       <= '0;
      first_pend <= 1'b0;
      valid_out  <= 1'b0;
      sop_out    <= 1'b0;
      eop_out    <= 1'b0;
      data_out   <= '0;
      err        <= 1'b0;
    end else begin
      if (drop_c || restart_c)
        err <= 1'b1;
      if (consume_c)
        valid_out <= 1'b0;
      // A completing symbol reloads the output register, overriding the drain above.
      if (accept_c && !drop_c) begin
        if (complete_c) begin
          data_out   <= word_c;
          sop_out    <= is_first_c;
          eop_out    <= eop_in;
          valid_out  <= 1'b1;
          lane_cnt   <= '0;
          part       <= '0;
          first_pend <= 1'b0;
          state      <= eop_in ? IDLE : IN_PKT;
        end else begin
          part       <= lanes_c[PART_W-1:0];
          lane_cnt   <= idx_c + 1'b1;
          first_pend <= is_first_c;
          state      <= IN_PKT;
        end
      end
    end
  end

endmodule
